// File: rtl/systemizer_host.sv
// Host-side sequencer for the systemizer: loads the matrix RAM from the host, starts a run,
// serves the systemizer's RAM port while it runs, then streams the RAM back to the host.
module systemizer_host #(
  parameter int DEPTH = 40,
  parameter int DW    = 4,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_go,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          res_valid,
  output logic          res_fail,
  output logic          res_success,
  output logic [15:0]   res_cycles,
  output logic          sys_start,
  input  logic          sys_done,
  input  logic          sys_fail,
  input  logic          sys_success,
  input  logic          sys_rd_en,
  input  logic [AW-1:0] sys_rd_addr,
  output logic [DW-1:0] sys_rd_data,
  input  logic          sys_wr_en,
  input  logic [AW-1:0] sys_wr_addr,
  input  logic [DW-1:0] sys_wr_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_URD   = 3'd4;
  localparam logic [2:0] S_UOUT  = 3'd5;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [2:0]    state;
  logic [AW-1:0] addr;
  logic [DW-1:0] mem [DEPTH];

  logic load_fire, run, sys_wr_ok, sys_rd_ok;

  assign run       = (state == S_RUN);
  assign load_fire = (state == S_LOAD) && in_valid;
  assign sys_wr_ok = run && sys_wr_en && (sys_wr_addr <= LAST);
  assign sys_rd_ok = (sys_rd_addr <= LAST);

  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_UOUT);
  assign busy      = (state != S_IDLE);
  assign sys_start = (state == S_START);

  // RAM has no reset; host and systemizer never own it at the same time.
  always_ff @(posedge clk) begin
    if (load_fire)      mem[addr]        <= in_data;
    else if (sys_wr_ok) mem[sys_wr_addr] <= sys_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr        <= '0;
      out_data    <= '0;
      res_valid   <= 1'b0;
      res_fail    <= 1'b0;
      res_success <= 1'b0;
      res_cycles  <= '0;
      sys_rd_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (cmd_go) begin
          state      <= S_LOAD;
          addr       <= '0;
          res_valid  <= 1'b0;
          res_cycles <= '0;
        end
        S_LOAD: if (in_valid) begin
          if (addr == LAST) begin
            state <= S_START;
            addr  <= '0;
          end else begin
            addr <= addr + AW'(1);
          end
        end
        S_START: begin
          res_cycles <= '0;
          state      <= S_RUN;
        end
        S_RUN: begin
          // Registered read; a same-address write this cycle lands after the read samples.
          if (sys_rd_en) sys_rd_data <= sys_rd_ok ? mem[sys_rd_addr] : '0;
          if (sys_done) begin
            res_fail    <= sys_fail;
            res_success <= sys_success;
            res_valid   <= 1'b1;
            addr        <= '0;
            state       <= S_URD;
          end else if (res_cycles != 16'hFFFF) begin
            res_cycles <= res_cycles + 16'd1;
          end
        end
        S_URD: begin
          out_data <= mem[addr];
          state    <= S_UOUT;
        end
        S_UOUT: if (out_ready) begin
          if (addr == LAST) begin
            state <= S_IDLE;
          end else begin
            addr  <= addr + AW'(1);
            state <= S_URD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systemizer_host.sv
// Scoreboard bench for systemizer_host: directed load/run/unload sequences, RAM port checks,
// backpressure and mid-load reset.
module tb_systemizer_host;
  localparam int DEPTH = 40;
  localparam int DW    = 4;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_go, in_valid, in_ready, out_valid, out_ready, busy;
  logic [DW-1:0] in_data, out_data, sys_rd_data, sys_wr_data;
  logic          res_valid, res_fail, res_success, sys_start;
  logic [15:0]   res_cycles;
  logic          sys_done, sys_fail, sys_success, sys_rd_en, sys_wr_en;
  logic [AW-1:0] sys_rd_addr, sys_wr_addr;

  systemizer_host #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_go(cmd_go),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .res_valid(res_valid), .res_fail(res_fail), .res_success(res_success),
    .res_cycles(res_cycles), .sys_start(sys_start), .sys_done(sys_done),
    .sys_fail(sys_fail), .sys_success(sys_success),
    .sys_rd_en(sys_rd_en), .sys_rd_addr(sys_rd_addr), .sys_rd_data(sys_rd_data),
    .sys_wr_en(sys_wr_en), .sys_wr_addr(sys_wr_addr), .sys_wr_data(sys_wr_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rd_q[$];
  logic          rd_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Unload monitor: every cycle a word is presented it must match the queue head;
  // the head is retired only on the handshake.
  always @(negedge clk) begin
    if (sys_start) n_start++;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unload_unexpected", 32'(out_valid), 32'(0));
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Systemizer read monitor: data is due one edge after the request.
  always @(posedge clk) rd_seen <= sys_rd_en;
  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'(1), 32'(0));
      else chk("sys_rd_data", 32'(sys_rd_data), 32'(rd_q.pop_front()));
    end
  end

  task automatic go;
    cmd_go = 1'b1; tick; cmd_go = 1'b0;
    chk("in_ready_after_go", 32'(in_ready), 32'(1));
  endtask

  task automatic load(input int n, input int mul);
    for (int i = 0; i < n; i++) begin
      if (i == 10) begin
        in_valid = 1'b0; in_data = '1;
        repeat (3) tick;
      end
      in_valid = 1'b1;
      in_data  = DW'((i * mul) % 16);
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic rd(input int a, input int expv);
    sys_rd_en = 1'b1; sys_rd_addr = AW'(a);
    rd_q.push_back(DW'(expv));
  endtask

  task automatic idle_sys;
    sys_rd_en = 1'b0; sys_wr_en = 1'b0; sys_done = 1'b0; cmd_go = 1'b0;
  endtask

  task automatic unload(input int bp_from);
    int cnt;
    for (int w = 0; w < DEPTH; w++) begin
      cnt = 0;
      while (!out_valid && cnt < 20) begin tick; cnt++; end
      if (cnt >= 20) chk("unload_timeout", 32'(w), 32'(DEPTH));
      if (w >= bp_from) repeat (5) tick;
      out_ready = 1'b1; tick; out_ready = 1'b0;
    end
    tick;
    chk("idle_after_unload", 32'(busy), 32'(0));
    chk("unload_queue_empty", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    int busy_seen;
    rst_n = 1'b0; cmd_go = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    sys_done = 1'b0; sys_fail = 1'b0; sys_success = 1'b0;
    sys_rd_en = 1'b0; sys_rd_addr = '0; sys_wr_en = 1'b0; sys_wr_addr = '0; sys_wr_data = '0;
    repeat (3) tick;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_res_fail", 32'(res_fail), 32'(0));
    chk("rst_res_success", 32'(res_success), 32'(0));
    chk("rst_res_cycles", 32'(res_cycles), 32'(0));
    chk("rst_sys_start", 32'(sys_start), 32'(0));
    chk("rst_sys_rd_data", 32'(sys_rd_data), 32'(0));
    rst_n = 1'b1;

    busy_seen = 0;
    repeat (100) begin tick; if (busy) busy_seen++; end
    chk("idle_100_busy", 32'(busy_seen), 32'(0));

    // Sequence 1: load i%16, exercise RAM port, done after 10 RUN cycles.
    n_start = 0;
    go;
    load(DEPTH, 1);
    chk("sys_start_pulse", 32'(sys_start), 32'(1));
    tick;                                    // RUN cycle 1 begins
    chk("sys_start_low", 32'(sys_start), 32'(0));
    rd(7, 7); tick;                          // cycle 1
    rd(3, 3); sys_wr_en = 1'b1; sys_wr_addr = 6'd3; sys_wr_data = 4'hA; tick;  // cycle 2
    sys_wr_en = 1'b0; rd(3, 'hA); tick;      // cycle 3
    rd(45, 0); sys_wr_en = 1'b1; sys_wr_addr = 6'd45; sys_wr_data = 4'h5; tick; // cycle 4
    sys_wr_en = 1'b0; rd(45, 0); cmd_go = 1'b1; tick;  // cycle 5, stray cmd_go
    idle_sys;
    repeat (4) tick;                         // cycles 6..9
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(i == 3 ? 4'hA : DW'(i % 16));
    sys_done = 1'b1; sys_fail = 1'b0; sys_success = 1'b1; tick;  // cycle 10
    sys_done = 1'b0; sys_success = 1'b0;
    chk("res_valid", 32'(res_valid), 32'(1));
    chk("res_success", 32'(res_success), 32'(1));
    chk("res_fail", 32'(res_fail), 32'(0));
    chk("res_cycles", 32'(res_cycles), 32'(9));
    chk("no_out_valid_yet", 32'(out_valid), 32'(0));
    chk("start_count_1", 32'(n_start), 32'(1));
    tick;
    chk("first_out_valid", 32'(out_valid), 32'(1));
    unload(20);
    chk("res_hold_valid", 32'(res_valid), 32'(1));
    chk("res_hold_cycles", 32'(res_cycles), 32'(9));

    // Sequence 2: reset partway through the load, then a clean run failing at once.
    go;
    load(20, 1);
    rst_n = 1'b0; #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_in_ready", 32'(in_ready), 32'(0));
    chk("abort_res_valid", 32'(res_valid), 32'(0));
    tick; rst_n = 1'b1; tick;
    n_start = 0;
    go;
    load(DEPTH, 3);
    tick;                                    // RUN cycle 1
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(DW'((i * 3) % 16));
    sys_done = 1'b1; sys_fail = 1'b1; tick;
    sys_done = 1'b0; sys_fail = 1'b0;
    chk("res2_fail", 32'(res_fail), 32'(1));
    chk("res2_success", 32'(res_success), 32'(0));
    chk("res2_cycles", 32'(res_cycles), 32'(0));
    chk("start_count_2", 32'(n_start), 32'(1));
    unload(DEPTH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end
endmodule
